// File: rtl/fpu_arb_pkg.sv
// Shared types for the FPU adder arbiter.
//   arb_state_e  : arbiter FSM state
//   fpu_flags_t  : adder status flags {error, overflow, underflow}
//   fp32_t       : IEEE-754 single-precision word
//   NUM_REQ_DEF  : default number of requesters
package fpu_arb_pkg;

    localparam int NUM_REQ_DEF = 4;

    typedef logic [31:0] fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic error;
        logic overflow;
        logic underflow;
    } fpu_flags_t;

endpackage

// File: rtl/fpu_adder_top.sv
// Combinational IEEE-754 single-precision adder/subtractor, round-to-nearest-even.
//   a_i, b_i    : operands
//   sub_i       : 1 = a_i - b_i, 0 = a_i + b_i
//   result_o    : rounded result (quiet NaN 0x7FC00000 on invalid)
//   error_o     : NaN operand or Inf - Inf
//   overflow_o  : finite operands rounded past the largest normal
//   underflow_o : result is subnormal/zero and inexact
module fpu_adder_top (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    output logic [31:0] result_o,
    output logic        error_o,
    output logic        overflow_o,
    output logic        underflow_o
);

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        swap;
    logic        s_big, s_small;
    logic [7:0]  e_big, e_small, eb_adj, es_adj, d;
    logic [22:0] f_big, f_small;
    logic [26:0] m_big, m_small, m_sh, mask;
    logic        sticky, rnd;
    logic [27:0] sum;
    logic [9:0]  e;
    logic [24:0] mant;
    logic [7:0]  e_enc;

    assign sa = a_i[31];
    assign sb = b_i[31] ^ sub_i;
    assign ea = a_i[30:23];
    assign eb = b_i[30:23];
    assign fa = a_i[22:0];
    assign fb = b_i[22:0];

    assign a_nan = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf = (eb == 8'hFF) && (fb == 23'd0);

    // Order by magnitude so the subtraction below never goes negative.
    assign swap    = {eb, fb} > {ea, fa};
    assign s_big   = swap ? sb : sa;
    assign s_small = swap ? sa : sb;
    assign e_big   = swap ? eb : ea;
    assign e_small = swap ? ea : eb;
    assign f_big   = swap ? fb : fa;
    assign f_small = swap ? fa : fb;

    // Subnormals use exponent 1 with no hidden bit.
    assign eb_adj  = (e_big == 8'd0) ? 8'd1 : e_big;
    assign es_adj  = (e_small == 8'd0) ? 8'd1 : e_small;
    assign d       = eb_adj - es_adj;
    assign m_big   = {e_big != 8'd0, f_big, 3'b000};
    assign m_small = {e_small != 8'd0, f_small, 3'b000};

    always_comb begin
        result_o    = '0;
        error_o     = 1'b0;
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        mask        = '0;
        m_sh        = '0;
        sticky      = 1'b0;
        sum         = '0;
        e           = '0;
        mant        = '0;
        rnd         = 1'b0;
        e_enc       = '0;

        if (d >= 8'd27) begin
            sticky = |m_small;
        end else begin
            mask   = ~(27'h7FF_FFFF << d);
            m_sh   = m_small >> d;
            sticky = |(m_small & mask);
        end
        m_sh[0] = m_sh[0] | sticky;

        if (s_big == s_small)
            sum = {1'b0, m_big} + {1'b0, m_sh};
        else
            sum = {1'b0, m_big} - {1'b0, m_sh};

        e = {2'b00, eb_adj};
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 10'd1;
        end else begin
            // Left-normalise, but stop at exponent 1 to produce subnormals.
            for (int i = 0; i < 26; i++) begin
                if (!sum[26] && (e > 10'd1)) begin
                    sum = sum << 1;
                    e   = e - 10'd1;
                end
            end
        end

        rnd  = sum[2] & (sum[1] | sum[0] | sum[3]);
        mant = {1'b0, sum[26:3]} + {24'd0, rnd};
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 10'd1;
        end
        e_enc = mant[23] ? e[7:0] : 8'd0;

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            result_o = 32'h7FC0_0000;
            error_o  = 1'b1;
        end else if (a_inf) begin
            result_o = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            result_o = {sb, 8'hFF, 23'd0};
        end else if (sum == 28'd0) begin
            result_o = {s_big & s_small, 31'd0};
        end else if (e >= 10'd255) begin
            result_o   = {s_big, 8'hFF, 23'd0};
            overflow_o = 1'b1;
        end else begin
            result_o    = {s_big, e_enc, mant[22:0]};
            underflow_o = (e_enc == 8'd0) && (sum[2:0] != 3'd0);
        end
    end

endmodule

// File: rtl/fpu_rr_picker.sv
// Round-robin request picker: first set bit of req_i searching upward from ptr_i.
//   req_i : request vector
//   ptr_i : highest-priority index
//   gnt_o : one-hot grant
//   idx_o : grant index
//   any_o : at least one request pending
module fpu_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     idx_o,
    output logic               any_o
);

    int cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one fpu_adder_top between NUM_REQ requesters, round-robin.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : per-requester request handshake
//   req_a, req_b, req_sub : per-requester operands and op select
//   rsp_valid/rsp_ready   : per-requester response handshake
//   rsp_result, rsp_error, rsp_overflow, rsp_underflow, rsp_id : held response
//   busy                  : FSM not idle
//   op_count              : completed responses, wrapping
//
// state | meaning
// IDLE  | waiting for a request; grants one combinationally and latches its operands
// EXEC  | registered operands drive the adder; result captured at the edge
// RESP  | response held on rsp_valid[grant] until the owner accepts it
module fpu_add_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][31:0] req_a,
    input  logic [NUM_REQ-1:0][31:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [31:0]              rsp_result,
    output logic                     rsp_error,
    output logic                     rsp_overflow,
    output logic                     rsp_underflow,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy,
    output logic [15:0]              op_count
);

    arb_state_e   state_q;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, grant_q;
    fp32_t        op_a_q, op_b_q, rsp_result_q;
    logic         op_sub_q;
    fpu_flags_t   flags_q, add_flags;
    logic [15:0]  op_count_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    fp32_t              add_result;
    logic               add_error, add_overflow, add_underflow;

    fpu_rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_picker (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    fpu_adder_top u_adder (
        .a_i         (op_a_q),
        .b_i         (op_b_q),
        .sub_i       (op_sub_q),
        .result_o    (add_result),
        .error_o     (add_error),
        .overflow_o  (add_overflow),
        .underflow_o (add_underflow)
    );

    assign add_flags = '{error: add_error, overflow: add_overflow, underflow: add_underflow};
    assign rr_ptr_d  = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

    // Gated by rst_n so no ready is offered while reset is held.
    assign req_ready = (state_q == ST_IDLE && rst_n) ? pick_gnt : '0;

    always_comb begin
        rsp_valid = '0;
        if (state_q == ST_RESP)
            rsp_valid[grant_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sub_q     <= 1'b0;
            rsp_result_q <= '0;
            flags_q      <= '0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        op_a_q   <= req_a[pick_idx];
                        op_b_q   <= req_b[pick_idx];
                        op_sub_q <= req_sub[pick_idx];
                        grant_q  <= pick_idx;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result_q <= add_result;
                    flags_q      <= add_flags;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[grant_q]) begin
                        rr_ptr_q   <= rr_ptr_d;
                        op_count_q <= op_count_q + 16'd1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_result    = rsp_result_q;
    assign rsp_error     = flags_q.error;
    assign rsp_overflow  = flags_q.overflow;
    assign rsp_underflow = flags_q.underflow;
    assign rsp_id        = grant_q;
    assign busy          = (state_q != ST_IDLE);
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
module tb_fpu_add_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [N-1:0]      req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
    logic [N-1:0][31:0] req_a, req_b;
    logic [31:0]       rsp_result;
    logic              rsp_error, rsp_overflow, rsp_underflow, busy;
    logic [1:0]        rsp_id;
    logic [15:0]       op_count;

    always #5 clk = ~clk;

    fpu_add_arbiter #(.NUM_REQ(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_sub       (req_sub),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_error     (rsp_error),
        .rsp_overflow  (rsp_overflow),
        .rsp_underflow (rsp_underflow),
        .rsp_id        (rsp_id),
        .busy          (busy),
        .op_count      (op_count)
    );

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [2:0]  flg;
        int          cyc;
    } sb_t;

    sb_t         sb[$];
    int          grant_ids[$];
    int          grant_cyc[$];
    logic [31:0] exp_res[N];
    logic [2:0]  exp_flg[N];
    int          ops_left[N];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic        prev_rv = 1'b0;
    logic [N-1:0] hs_req, hs_rsp;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic int oh_idx(logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++)
            if (v[i] && r < 0) r = i;
        return r;
    endfunction

    task automatic issue(int i, logic [31:0] a, logic [31:0] b, logic s,
                         logic [31:0] r, logic [2:0] f, int n);
        req_a[i]    = a;
        req_b[i]    = b;
        req_sub[i]  = s;
        exp_res[i]  = r;
        exp_flg[i]  = f;
        ops_left[i] = n;
        req_valid[i] = 1'b1;
    endtask

    // Sample at the falling edge, advance past the rising edge, then update requesters.
    task automatic step();
        sb_t e;
        @(negedge clk);
        cyc++;
        hs_req = req_valid & req_ready;
        hs_rsp = rsp_valid & rsp_ready;
        if (hs_req != '0) begin
            chk("req_ready_onehot", 32'($countones(req_ready)), 32'd1);
            e.id  = oh_idx(hs_req);
            e.res = exp_res[e.id];
            e.flg = exp_flg[e.id];
            e.cyc = cyc;
            sb.push_back(e);
            grant_ids.push_back(e.id);
            grant_cyc.push_back(cyc);
        end
        if (rsp_valid != '0 && !prev_rv) begin
            if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else                chk("rsp_latency", 32'(cyc), 32'(sb[0].cyc + 2));
        end
        prev_rv = (rsp_valid != '0);
        if (hs_rsp != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_no_entry", 32'(hs_rsp), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid_bit", 32'(rsp_valid), 32'(1) << e.id);
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_flags", 32'({rsp_error, rsp_overflow, rsp_underflow}), 32'(e.flg));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_req[i]) begin
                ops_left[i]--;
                if (ops_left[i] == 0) req_valid[i] = 1'b0;
            end
        end
        if (hs_rsp != '0) begin
            exp_cnt++;
            chk("op_count", 32'(op_count), 32'(exp_cnt));
        end
    endtask

    task automatic run_until_idle(int budget);
        int k = 0;
        while ((req_valid != '0 || sb.size() != 0) && k < budget) begin
            step();
            k++;
        end
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_no_pending", 32'(req_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_flags", 32'({rsp_error, rsp_overflow, rsp_underflow}), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready_held", 32'(req_ready), 32'd0);
        sb.delete();
        grant_ids.delete();
        grant_cyc.delete();
        exp_cnt = 16'd0;
        prev_rv = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        int k;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            ops_left[i] = 0;
            exp_res[i]  = '0;
            exp_flg[i]  = '0;
        end
        #3;
        do_reset();

        // Single requester: 1.0 + 1.0
        issue(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000, 1);
        run_until_idle(50);
        chk("t1_grant0", 32'(grant_ids.size() > 0 ? grant_ids[0] : -1), 32'd0);
        chk("t1_op_count", 32'(op_count), 32'd1);

        // All four pending from reset: order 0,1,2,3,0, one grant per 3 cycles
        issue(0, 32'h40A0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 3'b000, 2);
        issue(1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b010, 1);
        issue(2, 32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 3'b100, 1);
        issue(3, 32'h3FC0_0000, 32'h3E80_0000, 1'b0, 32'h3FE0_0000, 3'b000, 1);
        do_reset();
        run_until_idle(100);
        chk("t2_grants", 32'(grant_ids.size()), 32'd5);
        for (int i = 0; i < 5 && i < grant_ids.size(); i++)
            chk("t2_order", 32'(grant_ids[i]), 32'(i % N));
        for (int i = 1; i < grant_cyc.size(); i++)
            chk("t2_grant_gap", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);

        // Back-pressure on requester 3 with requester 1 waiting
        rsp_ready = 4'b0111;
        issue(3, 32'h3FC0_0000, 32'h3E80_0000, 1'b0, 32'h3FE0_0000, 3'b000, 1);
        k = 0;
        while (rsp_valid == '0 && k < 10) begin
            step();
            k++;
        end
        chk("t3_rsp_seen", 32'(rsp_valid), 32'b1000);
        issue(1, 32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 3'b000, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_hold_valid", 32'(rsp_valid), 32'b1000);
            chk("t3_hold_result", rsp_result, 32'h3FE0_0000);
            chk("t3_hold_id", 32'(rsp_id), 32'd3);
            chk("t3_no_req_ready", 32'(req_ready), 32'd0);
            chk("t3_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 4'b1111;
        step();
        chk("t3_idle_after", 32'(busy), 32'd0);
        chk("t3_next_grant", 32'(req_ready), 32'b0010);
        run_until_idle(50);

        // Reset while in EXEC discards the operation
        issue(2, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000, 1);
        k = 0;
        while (hs_req == '0 && k < 10) begin
            step();
            k++;
        end
        chk("t4_in_exec", 32'(busy), 32'd1);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_no_stale_rsp", 32'(rsp_valid), 32'd0);
            chk("t4_op_count", 32'(op_count), 32'd0);
        end

        // op_count wrap
        force dut.op_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.op_count_q;
        chk("t5_preload", 32'(op_count), 32'h0000_FFFF);
        exp_cnt = 16'hFFFF;
        issue(0, 32'h4000_0000, 32'hBF00_0000, 1'b0, 32'h3FC0_0000, 3'b000, 1);
        run_until_idle(50);
        chk("t5_wrap", 32'(op_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpu_add_arbiter.md
# fpu_add_arbiter

Shares one `fpu_adder_top` instance between `NUM_REQ` independent requesters. Each requester uses a valid/ready request channel and a per-requester valid/ready response channel. The block arbitrates round-robin, registers the granted operands, and captures the adder result and flags one cycle later. It holds the response until the owner accepts it. It sits between the FPU adder datapath and the blocks that issue add/subtract operations.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `IDW`, default `$clog2(NUM_REQ)`: width of the grant index.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  `NUM_REQ`: request pending, one bit per requester.
- `req_ready`  out  `NUM_REQ`: request accepted; at most one bit high.
- `req_a`  in  `NUM_REQ`×32: operand A, IEEE-754 single.
- `req_b`  in  `NUM_REQ`×32: operand B, IEEE-754 single.
- `req_sub`  in  `NUM_REQ`: 1 = subtract (A−B), 0 = add.
- `rsp_valid`  out  `NUM_REQ`: response available for requester i; at most one bit high.
- `rsp_ready`  in  `NUM_REQ`: requester i accepts the response.
- `rsp_result`  out  32: captured adder result.
- `rsp_error`  out  1: captured adder error flag (NaN / Inf−Inf).
- `rsp_overflow`  out  1: captured adder overflow flag.
- `rsp_underflow`  out  1: captured adder underflow flag.
- `rsp_id`  out  `IDW`: index of the requester owning the current response.
- `busy`  out  1: high in every state other than IDLE.
- `op_count`  out  16: number of completed responses; wraps 0xFFFF→0x0000.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` bit is set, pick the first set bit searching upward from `rr_ptr`, modulo `NUM_REQ`.
  - Drive that bit of `req_ready` combinationally.
  - Latch `req_a`, `req_b`, `req_sub` and the grant index into the operand registers. Go to EXEC.
  - If no request is pending, stay in IDLE.
- **EXEC**
  - The registered operands drive the adder.
  - At the end of the cycle, capture `result`, `error`, `overflow` and `underflow` into the response registers. Go to RESP.
  - `req_ready` is all zero.
- **RESP**
  - Drive `rsp_valid[grant]` = 1. `rsp_result`, `rsp_id` and the flags are stable.
  - When `rsp_ready[grant]` is high:
    - go to IDLE;
    - set `rr_ptr` to grant+1, wrapping from `NUM_REQ`−1 to 0;
    - increment `op_count`.
  - `rsp_ready` bits of other requesters are ignored.
- Requester rule: `req_valid` and operands stay stable until `req_ready` is seen. Violations are not detected.
- Response data is passed through from the adder unmodified (no re-rounding or NaN canonicalisation).
- A requester may keep `req_valid` high while its own response is pending. It is re-eligible in the next IDLE, subject to `rr_ptr`.

## Timing
- Request handshake in cycle T → `rsp_valid` high in cycle T+2.
- With `rsp_ready` held high, the next grant occurs at T+3. Peak throughput is one operation per 3 cycles.
- No combinational path from `req_*` to `rsp_*`. The only combinational output path is `req_valid` → `req_ready`, in IDLE.
- Reset values:
  - state = IDLE, `rr_ptr` = 0;
  - `req_ready` = 0, `rsp_valid` = 0, `busy` = 0;
  - `rsp_result` = 0, all flags = 0, `rsp_id` = 0;
  - `op_count` = 0.
- Reset asserted mid-operation (EXEC or RESP): the in-flight operation is discarded, no response is issued, `op_count` is not incremented.
- Simultaneous requests: exactly one grant. Losers keep `req_valid` and are served on later IDLE visits, in rotation order.
- `rsp_ready` high before `rsp_valid`: no effect until RESP.

## Structure
- Package `fpu_arb_pkg` holds:
  - the state enum (IDLE/EXEC/RESP);
  - the packed flag struct {error, overflow, underflow};
  - the 32-bit float typedef;
  - the default `NUM_REQ` constant.
- The existing `fpu_adder_top` is instantiated unmodified. Its debug/internal outputs are left unconnected.
- One natural new sub-module: `fpu_rr_picker`. It is combinational, takes a `NUM_REQ` request vector plus `rr_ptr`, and returns a one-hot grant and the grant index.

## Test plan
- Requester 0 only, A=0x3F800000, B=0x3F800000, sub=0 → `rsp_valid[0]` at T+2, `rsp_result`=0x40000000, flags 0, `op_count`=1.
- Requesters 0..3 all valid from reset, with distinct ops:
  - 0x40A00000−0x40000000 must return 0x40400000;
  - grant order must be 0,1,2,3,0;
  - each `rsp_id` must match its owner.
- Requester 2: 0x7F800000 + 0xFF800000 → `rsp_error`=1. Requester 1: 0x7F7FFFFF + 0x7F7FFFFF → `rsp_result`=0x7F800000, `rsp_overflow`=1.
- Back-pressure: hold `rsp_ready`=0 for 10 cycles → `rsp_valid` and data stay stable, no new `req_ready`, `busy`=1. Then release → IDLE next cycle.
- Assert `rst_n`=0 in EXEC → all outputs return to their reset values immediately. After release, no stale response, `op_count` unchanged.
- Preload `op_count` to 0xFFFF via 65535 operations (or a forced value) → the next completion gives 0x0000.
